regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
//
// PURPOSE
// Write-side companion of the Eka register file: the only driver of its write port (write_en/write_addr/write_data).
// Arbitrates ALU and LSU results, registers one write per cycle, and keeps a per-register busy scoreboard.
// Gives decode a forwarding/hazard view of the write in flight. Sits between execute/LSU and the register file.
//
// PARAMETERS
// XLEN        32  data width of results and register file entries
// REG_ADDR_W  5   register index width; NUM_REGS = 2**REG_ADDR_W
//
// PORTS
// clk           in   1           rising-edge clock
// reset_n       in   1           asynchronous active-low reset
// issue_valid   in   1           decode issues an instruction that writes issue_rd
// issue_rd      in   REG_ADDR_W  destination register of issued instruction
// alu_valid     in   1           ALU result available
// alu_ready     out  1           ALU result accepted this cycle
// alu_rd        in   REG_ADDR_W  ALU destination
// alu_data      in   XLEN        ALU result
// lsu_valid     in   1           load data available (always accepted)
// lsu_rd        in   REG_ADDR_W  load destination
// lsu_data      in   XLEN        load data
// rf_we         out  1           to register file write_en
// rf_waddr      out  REG_ADDR_W  to register file write_addr
// rf_wdata      out  XLEN        to register file write_data
// rs1, rs2      in   REG_ADDR_W  decode source indices
// fwd_hit1/2    out  1           rsN matches the write in flight
// fwd_data1/2   out  XLEN        rf_wdata when fwd_hitN, else 0
// hazard1/2     out  1           busy[rsN] && !fwd_hitN; decode must stall
// busy          out  NUM_REGS    scoreboard vector
// idle          out  1           busy==0 && !rf_we
// err_unexp     out  1           sticky: write to a non-busy nonzero register
//
// BEHAVIOUR
// - Reset (async, reset_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, err_unexp=0. alu_ready comb = !lsu_valid.
// - Arbitration: fixed priority LSU > ALU; lsu accepted whenever lsu_valid; alu accepted iff alu_valid && !lsu_valid.
// - Write stage: one registered stage; accepted result appears on rf_* the next cycle, regfile commits the edge after
//   (issue-to-architectural latency 2 edges). No acceptance -> rf_we<=0, rf_waddr/rf_wdata hold last value.
// - rd==0: accepted and consumed, but rf_we<=0 and no scoreboard/err effect.
// - Scoreboard: on edge, issue_valid && issue_rd!=0 sets busy[issue_rd]; accepted write with rd!=0 clears busy[rd].
//   Same rd set and cleared on one edge -> set wins (the new issue owns it). busy[0] constant 0.
// - Accepted write to rd!=0 with busy[rd]==0 (after set/clear resolution input state) -> err_unexp<=1 until reset;
//   write still performed.
// - Forwarding (comb): fwd_hitN = rf_we && rf_waddr==rsN && rsN!=0. Covers the cycle where busy is already clear
//   but regfile has not yet committed.
// - hazardN = busy[rsN] && !fwd_hitN (busy[0]=0 so x0 never hazards).
// - Reset mid-operation: in-flight write dropped (rf_we=0 immediately), scoreboard cleared; upstream re-issues.
//
// STRUCTURE
// - Shared package eka_pkg: XLEN, REG_ADDR_W, NUM_REGS, typedef reg_idx_t, typedef xword_t.
// - One sub-module: regfile_scoreboard (busy vector set/clear, set-wins, err_unexp). Arbiter, write stage,
//   forwarding remain in the top.
//
// TESTING
// 1. Reset with all inputs active -> rf_we=0, busy=0, idle=1, err_unexp=0; release -> still idle.
// 2. issue rd=5; next cycle alu rd=5 data=0xDEADBEEF -> busy[5]=1 until accept edge; rf_we=1 addr=5
//    data=0xDEADBEEF one cycle; rs1=5 then fwd_hit1=1 fwd_data1=0xDEADBEEF, hazard1=0.
// 3. issue rd=3 and rd=7; alu(rd=3) and lsu(rd=7) same cycle -> alu_ready=0, LSU written first, ALU held and
//    written next cycle; busy[7] then busy[3] clear in order.
// 4. Same edge: issue rd=9 and alu writes rd=9 (busy) -> busy[9] remains 1; hazard on rs2=9 after fwd cycle.
// 5. alu write rd=0 data=0x1 -> alu_ready=1, rf_we stays 0, busy unchanged; write rd=12 with busy[12]=0 ->
//    err_unexp=1 sticky, rf_we=1 addr=12.
// 6. Assert reset_n low while rf_we=1 -> rf_we=0 asynchronously, busy=0.

Source files
------------

// File: rtl/eka_pkg.sv
// Shared types and sizes for the Eka register file and its write-back logic.
package eka_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xword_t;
  typedef logic [NUM_REGS-1:0]   busy_t;

  // One-hot mask selecting register idx; x0 never gets a bit.
  function automatic busy_t reg_mask(input reg_idx_t idx);
    busy_t mask;
    mask    = busy_t'(1) << idx;
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, write-back clears, a same-edge
// set wins over a clear, and a write to a register nobody is waiting on
// raises a sticky error flag.
module regfile_scoreboard
  import eka_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     i_set_valid,
  input  reg_idx_t i_set_rd,
  input  logic     i_clr_valid,
  input  reg_idx_t i_clr_rd,
  output busy_t    o_busy,
  output logic     o_err_unexp
);

  busy_t r_busy;
  logic  r_err_unexp;
  busy_t w_set_mask;
  busy_t w_clr_mask;
  busy_t w_busy_next;
  logic  w_unexp;

  // Next busy vector: clear first, then OR in the set so a new issue owns rd.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    w_set_mask  = '0;
    w_clr_mask  = '0;
    w_unexp     = 1'b0;
    if (i_set_valid) w_set_mask = reg_mask(i_set_rd);
    if (i_clr_valid) begin
      w_clr_mask = reg_mask(i_clr_rd);
      w_unexp    = (i_clr_rd != '0) && !r_busy[i_clr_rd];
    end
    w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;
  end

  // Scoreboard and sticky error state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy      <= '0;
      r_err_unexp <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_busy <= w_busy_next;
      if (w_unexp) r_err_unexp <= 1'b1;
    end
  end

  assign o_busy      = r_busy;
  assign o_err_unexp = r_err_unexp;

endmodule

// File: rtl/regfile_writeback.sv
// Write side of the Eka register file: LSU-over-ALU arbitration, a single
// registered write stage driving the regfile write port, busy scoreboard,
// and the forwarding/hazard view decode uses for its two source operands.
module regfile_writeback
  import eka_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     issue_valid,
  input  reg_idx_t issue_rd,
  input  logic     alu_valid,
  output logic     alu_ready,
  input  reg_idx_t alu_rd,
  input  xword_t   alu_data,
  input  logic     lsu_valid,
  input  reg_idx_t lsu_rd,
  input  xword_t   lsu_data,
  output logic     rf_we,
  output reg_idx_t rf_waddr,
  output xword_t   rf_wdata,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  output logic     fwd_hit1,
  output logic     fwd_hit2,
  output xword_t   fwd_data1,
  output xword_t   fwd_data2,
  output logic     hazard1,
  output logic     hazard2,
  output busy_t    busy,
  output logic     idle,
  output logic     err_unexp
);

  logic     w_acc_valid;
  reg_idx_t w_acc_rd;
  xword_t   w_acc_data;
  logic     r_we;
  reg_idx_t r_waddr;
  xword_t   r_wdata;
  busy_t    w_busy;

  // Fixed priority: loads cannot be back-pressured, so the ALU waits.
  always_comb begin
    w_acc_valid = lsu_valid || alu_valid;
    w_acc_rd    = alu_rd;
    w_acc_data  = alu_data;
    if (lsu_valid) begin
      w_acc_rd   = lsu_rd;
      w_acc_data = lsu_data;
    end
  end

  assign alu_ready = !lsu_valid;

  // Write stage: a result to x0 is consumed without touching the port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_acc_valid && (w_acc_rd != '0)) begin
      r_we    <= 1'b1;
      r_waddr <= w_acc_rd;
      r_wdata <= w_acc_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_set_valid (issue_valid),
    .i_set_rd    (issue_rd),
    .i_clr_valid (w_acc_valid),
    .i_clr_rd    (w_acc_rd),
    .o_busy      (w_busy),
    .o_err_unexp (err_unexp)
  );

  // Forwarding covers the cycle where busy has cleared but the regfile has not committed.
  always_comb begin
    fwd_hit1  = r_we && (r_waddr == rs1) && (rs1 != '0);
    fwd_hit2  = r_we && (r_waddr == rs2) && (rs2 != '0);
    fwd_data1 = fwd_hit1 ? r_wdata : '0;
    fwd_data2 = fwd_hit2 ? r_wdata : '0;
    hazard1   = w_busy[rs1] && !fwd_hit1;
    hazard2   = w_busy[rs2] && !fwd_hit2;
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign busy     = w_busy;
  assign idle     = (w_busy == '0) && !r_we;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic
// compared against a behavioural model of the write-back rules.
module tb_regfile_writeback;
  import eka_pkg::*;

  logic     clk = 1'b0;
  logic     reset_n;
  logic     issue_valid, alu_valid, lsu_valid;
  reg_idx_t issue_rd, alu_rd, lsu_rd, rs1, rs2;
  xword_t   alu_data, lsu_data;
  logic     alu_ready, rf_we, fwd_hit1, fwd_hit2, hazard1, hazard2, idle, err_unexp;
  reg_idx_t rf_waddr;
  xword_t   rf_wdata, fwd_data1, fwd_data2;
  busy_t    busy;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  logic [31:0] m_busy;
  logic        m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  logic        m_err;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs1(rs1), .rs2(rs2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .hazard1(hazard1), .hazard2(hazard2),
    .busy(busy), .idle(idle), .err_unexp(err_unexp)
  );

  task automatic model_reset();
    m_busy = '0; m_we = 1'b0; m_waddr = 0; m_wdata = '0; m_err = 1'b0;
  endtask

  task automatic clear_inputs();
    issue_valid = 0; issue_rd = '0; alu_valid = 0; alu_rd = '0; alu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0; rs1 = '0; rs2 = '0;
  endtask

  // One clock edge: the model consumes the inputs presented before the edge.
  task automatic tick();
    int          rd;
    logic [31:0] data;
    logic        acc;
    logic [31:0] nb;
    logic        nwe, nerr;
    int          naddr;
    logic [31:0] ndata;
    acc = lsu_valid || alu_valid;
    rd   = lsu_valid ? int'(lsu_rd) : int'(alu_rd);
    data = lsu_valid ? lsu_data : alu_data;
    nb = m_busy; nwe = 1'b0; naddr = m_waddr; ndata = m_wdata; nerr = m_err;
    if (acc && rd != 0) begin
      if (!m_busy[rd]) nerr = 1'b1;
      nb[rd] = 1'b0;
      nwe = 1'b1; naddr = rd; ndata = data;
    end
    if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
    @(posedge clk);
    m_busy = nb; m_we = nwe; m_waddr = naddr; m_wdata = ndata; m_err = nerr;
    #1;
  endtask

  task automatic test_reset();
    issue_valid = 1; issue_rd = 5'd1; alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h22; rs1 = 5'd2; rs2 = 5'd3;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %0b want 0", rf_we); end
    n_checks++; if (busy !== '0) begin n_errors++; $display("FAIL reset_busy: got %h want 0", busy); end
    n_checks++; if (idle !== 1'b1) begin n_errors++; $display("FAIL reset_idle: got %0b want 1", idle); end
    n_checks++; if (err_unexp !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %0b want 0", err_unexp); end
    n_checks++; if (rf_waddr !== '0 || rf_wdata !== '0) begin n_errors++; $display("FAIL reset_port: got %0d/%h want 0/0", rf_waddr, rf_wdata); end
    clear_inputs();
    model_reset();
    reset_n = 1'b1;
    tick();
    n_checks++; if (idle !== 1'b1 || rf_we !== 1'b0) begin n_errors++; $display("FAIL release_idle: got idle=%0b we=%0b want 1/0", idle, rf_we); end
  endtask

  task automatic test_basic_write();
    issue_valid = 1; issue_rd = 5'd5;
    tick();
    issue_valid = 0; alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (busy[5] !== 1'b1) begin n_errors++; $display("FAIL basic_busy_set: got %0b want 1", busy[5]); end
    n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL basic_ready: got %0b want 1", alu_ready); end
    tick();
    alu_valid = 0; rs1 = 5'd5;
    #1;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL basic_port: got we=%0b a=%0d d=%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (busy[5] !== 1'b0) begin n_errors++; $display("FAIL basic_busy_clr: got %0b want 0", busy[5]); end
    n_checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hDEADBEEF || hazard1 !== 1'b0) begin n_errors++; $display("FAIL basic_fwd: got hit=%0b d=%h hz=%0b want 1/deadbeef/0", fwd_hit1, fwd_data1, hazard1); end
    tick();
    n_checks++; if (rf_we !== 1'b0 || fwd_hit1 !== 1'b0 || fwd_data1 !== '0) begin n_errors++; $display("FAIL basic_one_cycle: got we=%0b hit=%0b d=%h want 0/0/0", rf_we, fwd_hit1, fwd_data1); end
    rs1 = '0;
  endtask

  task automatic test_priority();
    issue_valid = 1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd7;
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hAAAA0003;
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'hBBBB0007;
    #1;
    n_checks++; if (alu_ready !== 1'b0) begin n_errors++; $display("FAIL prio_ready_low: got %0b want 0", alu_ready); end
    tick();
    lsu_valid = 0;
    #1;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hBBBB0007) begin n_errors++; $display("FAIL prio_lsu_first: got we=%0b a=%0d d=%h want 1/7/bbbb0007", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (busy[7] !== 1'b0 || busy[3] !== 1'b1) begin n_errors++; $display("FAIL prio_busy_mid: got b7=%0b b3=%0b want 0/1", busy[7], busy[3]); end
    n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL prio_ready_high: got %0b want 1", alu_ready); end
    tick();
    alu_valid = 0;
    #1;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAAAA0003) begin n_errors++; $display("FAIL prio_alu_next: got we=%0b a=%0d d=%h want 1/3/aaaa0003", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (busy[3] !== 1'b0) begin n_errors++; $display("FAIL prio_busy_end: got %0b want 0", busy[3]); end
    tick();
  endtask

  task automatic test_set_wins();
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h00000909;
    tick();
    issue_valid = 0; alu_valid = 0; rs2 = 5'd9;
    #1;
    n_checks++; if (busy[9] !== 1'b1) begin n_errors++; $display("FAIL setwins_busy: got %0b want 1", busy[9]); end
    n_checks++; if (fwd_hit2 !== 1'b1 || hazard2 !== 1'b0 || fwd_data2 !== 32'h00000909) begin n_errors++; $display("FAIL setwins_fwd: got hit=%0b hz=%0b d=%h want 1/0/00000909", fwd_hit2, hazard2, fwd_data2); end
    tick();
    n_checks++; if (fwd_hit2 !== 1'b0 || hazard2 !== 1'b1) begin n_errors++; $display("FAIL setwins_hazard: got hit=%0b hz=%0b want 0/1", fwd_hit2, hazard2); end
    n_checks++; if (err_unexp !== 1'b0) begin n_errors++; $display("FAIL setwins_err: got %0b want 0", err_unexp); end
    rs2 = '0;
  endtask

  task automatic test_zero_and_unexpected();
    busy_t snap;
    snap = busy;
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1;
    #1;
    n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL x0_ready: got %0b want 1", alu_ready); end
    tick();
    alu_valid = 0;
    #1;
    n_checks++; if (rf_we !== 1'b0 || busy !== snap) begin n_errors++; $display("FAIL x0_noeffect: got we=%0b busy=%h want 0/%h", rf_we, busy, snap); end
    n_checks++; if (busy[12] !== 1'b0) begin n_errors++; $display("FAIL unexp_pre: got %0b want 0", busy[12]); end
    alu_valid = 1; alu_rd = 5'd12; alu_data = 32'hC0C0C0C0;
    tick();
    alu_valid = 0;
    #1;
    n_checks++; if (err_unexp !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd12) begin n_errors++; $display("FAIL unexp_flag: got err=%0b we=%0b a=%0d want 1/1/12", err_unexp, rf_we, rf_waddr); end
    repeat (3) tick();
    n_checks++; if (err_unexp !== 1'b1) begin n_errors++; $display("FAIL unexp_sticky: got %0b want 1", err_unexp); end
  endtask

  task automatic test_async_reset();
    issue_valid = 1; issue_rd = 5'd4;
    tick();
    issue_rd = 5'd6;
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h44444444;
    tick();
    issue_valid = 0; alu_valid = 0;
    #1;
    n_checks++; if (rf_we !== 1'b1 || busy[6] !== 1'b1) begin n_errors++; $display("FAIL areset_pre: got we=%0b b6=%0b want 1/1", rf_we, busy[6]); end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (rf_we !== 1'b0 || busy !== '0 || err_unexp !== 1'b0) begin n_errors++; $display("FAIL areset_drop: got we=%0b busy=%h err=%0b want 0/0/0", rf_we, busy, err_unexp); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic exp_hit1, exp_hit2;
    for (int i = 0; i < 400; i++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = reg_idx_t'($urandom_range(0, 7));
      alu_valid   = ($urandom_range(0, 1) == 1);
      alu_rd      = reg_idx_t'($urandom_range(0, 7));
      alu_data    = $urandom;
      lsu_valid   = ($urandom_range(0, 3) == 0);
      lsu_rd      = reg_idx_t'($urandom_range(0, 7));
      lsu_data    = $urandom;
      rs1         = reg_idx_t'($urandom_range(0, 7));
      rs2         = reg_idx_t'($urandom_range(0, 7));
      #1;
      exp_hit1 = m_we && (m_waddr == int'(rs1)) && (rs1 != 0);
      exp_hit2 = m_we && (m_waddr == int'(rs2)) && (rs2 != 0);
      n_checks++; if (rf_we !== m_we || (m_we && (int'(rf_waddr) != m_waddr || rf_wdata !== m_wdata))) begin n_errors++; $display("FAIL rnd_port[%0d]: got we=%0b a=%0d d=%h want %0b/%0d/%h", i, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata); end
      n_checks++; if (busy !== m_busy || err_unexp !== m_err) begin n_errors++; $display("FAIL rnd_sb[%0d]: got busy=%h err=%0b want %h/%0b", i, busy, err_unexp, m_busy, m_err); end
      n_checks++; if (alu_ready !== !lsu_valid || idle !== (m_busy == 0 && !m_we)) begin n_errors++; $display("FAIL rnd_rdy_idle[%0d]: got rdy=%0b idle=%0b want %0b/%0b", i, alu_ready, idle, !lsu_valid, (m_busy == 0 && !m_we)); end
      n_checks++; if (fwd_hit1 !== exp_hit1 || fwd_data1 !== (exp_hit1 ? m_wdata : 32'h0) || hazard1 !== (m_busy[rs1] && !exp_hit1)) begin n_errors++; $display("FAIL rnd_src1[%0d]: got hit=%0b d=%h hz=%0b want %0b/%h/%0b", i, fwd_hit1, fwd_data1, hazard1, exp_hit1, (exp_hit1 ? m_wdata : 32'h0), (m_busy[rs1] && !exp_hit1)); end
      n_checks++; if (fwd_hit2 !== exp_hit2 || fwd_data2 !== (exp_hit2 ? m_wdata : 32'h0) || hazard2 !== (m_busy[rs2] && !exp_hit2)) begin n_errors++; $display("FAIL rnd_src2[%0d]: got hit=%0b d=%h hz=%0b want %0b/%h/%0b", i, fwd_hit2, fwd_data2, hazard2, exp_hit2, (exp_hit2 ? m_wdata : 32'h0), (m_busy[rs2] && !exp_hit2)); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    reset_n = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_basic_write();
    test_priority();
    test_set_wins();
    test_zero_and_unexpected();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
